reg_bank: RTL and testbench
===========================

# reg_bank

Register file for the 8086-style datapath, directly downstream of the write-enable decoder. Holds AX, CX, DX, BX, SP, BP, SI and DI as twelve independently writable slices: four byte-pair registers (low and high byte) plus four word registers. The block consumes the decoder's 12-bit one-hot/pair write-enable vector and a 16-bit write bus. It serves two registered read ports addressed with the same {W, SEL} encoding the decoder uses.

## Interface
- No parameters; widths fixed (16-bit data, 12 write slices, 4-bit select).
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- WE  in  12  slice write enables: [11]=AL, [10]=CL, [9]=DL, [8]=BL, [7]=AH, [6]=CH, [5]=DH, [4]=BH, [3]=SP, [2]=BP, [1]=SI, [0]=DI.
- DIN  in  16  write data.
- RD_EN  in  1  read request; samples both read addresses.
- RW_A, RW_B  in  1  read width per port: 0 = byte, 1 = word.
- RSEL_A, RSEL_B  in  4  read select per port.
  - Byte mode (W=0): 0..7 = AL, CL, DL, BL, AH, CH, DH, BH; bit 3 of RSEL is ignored.
  - Word mode (W=1): 0..7 = AX, CX, DX, BX, SP, BP, SI, DI; bit 3 of RSEL is ignored.
- DOUT_A, DOUT_B  out  16  registered read data.
- RD_VALID  out  1  high one cycle after an accepted RD_EN.

## Operation
- Storage:
  - AX, CX, DX, BX: low byte and high byte registers, 8 bits each.
  - SP, BP, SI, DI: 16-bit registers.
- Write rules (per pair, evaluated independently each cycle):
  - Low enable only: low byte <= DIN[7:0].
  - High enable only: high byte <= DIN[7:0].
  - Both enables: low <= DIN[7:0], high <= DIN[15:8].
  - Word register enable (SP/BP/SI/DI): register <= DIN.
  - Multiple pairs enabled in the same cycle are all written with the same rules; no enable combination is illegal.
  - WE = 0 leaves all state unchanged.
- Read:
  - On RD_EN=1, each port captures the selected value into DOUT_x.
  - Byte reads are zero-extended to 16 bits ({8'h00, byte}).
  - Word reads of AX..BX return {high, low}.
- When RD_EN=0, DOUT_A and DOUT_B hold their previous values.
- Reset values: all twelve slices 0, DOUT_A = DOUT_B = 16'h0000, RD_VALID = 0.

## Timing
- Write latency: one edge; state is visible to a read issued in the following cycle.
- Read latency: one cycle. RD_EN at edge n gives DOUT and RD_VALID at edge n+1.
- RD_VALID is a one-cycle pulse per RD_EN cycle. Back-to-back RD_EN keeps RD_VALID high continuously, with new data each cycle.
- Same-cycle write and read of an overlapping slice: behaviour is set by the configuration macro (below).
- Both ports may select the same register; both return identical data.
- RST during a write: reset wins, and no slice takes DIN.
- RST during a read: reset wins, DOUT is cleared, and RD_VALID is 0 on the next cycle.
- Ongoing operation resumes on the first cycle after RST deasserts; no warm-up cycles.

## Configuration
- REG_BYPASS_EN defined:
  - A read whose selected slice is written in the same cycle returns the new value, assembled per byte.
  - Only slices actually written are bypassed; untouched bytes come from storage.
  - Example: AH written while AX is read gives {new AH, stored AL}.
- REG_BYPASS_EN undefined: same-cycle reads return the pre-write value, and the write becomes visible one cycle later.

## Test plan
- Reset, then RD_EN with word reads of all 8 registers -> every DOUT = 16'h0000; RD_VALID pulses one cycle after each RD_EN.
- WE=12'b100010000000, DIN=16'h1234; next cycle read with W=1/SEL=0, W=0/SEL=0 and W=0/SEL=4 -> 16'h1234, 16'h0034, 16'h0012.
- Then WE=12'b000010000000 (AH only), DIN=16'h00AB; read AX -> 16'hAB34. Then WE=12'b000000001000, DIN=16'hFFFE; read SP -> 16'hFFFE, with AX unchanged.
- Write DX=16'h5A5A and read DX in the same cycle:
  - With REG_BYPASS_EN, DOUT = 16'h5A5A.
  - Without it, DOUT = the old value, and 16'h5A5A appears on a read one cycle later.
- Port A reads BX while port B reads BL, with BX=16'hC3F0 -> DOUT_A = 16'hC3F0, DOUT_B = 16'h00F0 in the same cycle.
- Assert RST together with WE=12'hFFF, DIN=16'hFFFF and RD_EN=1 -> nothing written, RD_VALID = 0, and all later reads return 0.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: AX..DI register file, twelve write slices, two registered read ports.
// Build option: define REG_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_bank (
   input  logic        CLK,
   input  logic        RST,
   input  logic [11:0] WE,
   input  logic [15:0] DIN,
   input  logic        RD_EN,
   input  logic        RW_A,
   input  logic        RW_B,
   input  logic [3:0]  RSEL_A,
   input  logic [3:0]  RSEL_B,
   output logic [15:0] DOUT_A,
   output logic [15:0] DOUT_B,
   output logic        RD_VALID
);

   logic [3:0][7:0]  r_lo;
   logic [3:0][7:0]  r_hi;
   logic [3:0][15:0] r_wd;
   logic [15:0]      r_dout_a;
   logic [15:0]      r_dout_b;
   logic             r_rd_valid;

   logic [3:0]       w_lo_en;
   logic [3:0]       w_hi_en;
   logic [3:0]       w_wd_en;
   logic [3:0][7:0]  w_lo_nx;
   logic [3:0][7:0]  w_hi_nx;
   logic [3:0][15:0] w_wd_nx;
   logic [3:0][7:0]  w_lo_rd;
   logic [3:0][7:0]  w_hi_rd;
   logic [3:0][15:0] w_wd_rd;
   logic [15:0]      w_rd_a;
   logic [15:0]      w_rd_b;

   // Slice order in WE: pair i low at 11-i, high at 7-i, word i at 3-i
   always_comb begin
      w_lo_en = '0;
      w_hi_en = '0;
      w_wd_en = '0;
      for (int i = 0; i < 4; i++) begin
         w_lo_en[i] = WE[11-i];
         w_hi_en[i] = WE[7-i];
         w_wd_en[i] = WE[3-i];
      end
   end

   always_comb begin
      w_lo_nx = r_lo;
      w_hi_nx = r_hi;
      w_wd_nx = r_wd;
      for (int i = 0; i < 4; i++) begin
         if (w_lo_en[i])
            w_lo_nx[i] = DIN[7:0];
         if (w_hi_en[i])
            w_hi_nx[i] = w_lo_en[i] ? DIN[15:8] : DIN[7:0];
         if (w_wd_en[i])
            w_wd_nx[i] = DIN;
      end
   end

`ifdef REG_BYPASS_EN
   assign w_lo_rd = w_lo_nx;
   assign w_hi_rd = w_hi_nx;
   assign w_wd_rd = w_wd_nx;
`else
   assign w_lo_rd = r_lo;
   assign w_hi_rd = r_hi;
   assign w_wd_rd = r_wd;
`endif

   function automatic logic [15:0] f_read(
      input logic             w,
      input logic [3:0]       sel,
      input logic [3:0][7:0]  lo,
      input logic [3:0][7:0]  hi,
      input logic [3:0][15:0] wd
   );
      logic [1:0] idx;
      idx    = sel[1:0];
      f_read = '0;
      // sel[3] is a don't-care in both widths
      unique casez ({w, sel})
         5'b0_?0?? : f_read = {8'h00, lo[idx]};
         5'b0_?1?? : f_read = {8'h00, hi[idx]};
         5'b1_?0?? : f_read = {hi[idx], lo[idx]};
         5'b1_?1?? : f_read = wd[idx];
         default   : f_read = '0;
      endcase
   endfunction

   assign w_rd_a = f_read(RW_A, RSEL_A, w_lo_rd, w_hi_rd, w_wd_rd);
   assign w_rd_b = f_read(RW_B, RSEL_B, w_lo_rd, w_hi_rd, w_wd_rd);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_lo       <= '0;
         r_hi       <= '0;
         r_wd       <= '0;
         r_dout_a   <= '0;
         r_dout_b   <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_lo       <= w_lo_nx;
         r_hi       <= w_hi_nx;
         r_wd       <= w_wd_nx;
         r_rd_valid <= RD_EN;
         if (RD_EN) begin
            r_dout_a <= w_rd_a;
            r_dout_b <= w_rd_b;
         end
      end
   end

   assign DOUT_A   = r_dout_a;
   assign DOUT_B   = r_dout_b;
   assign RD_VALID = r_rd_valid;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed plan plus random traffic against a byte/word model.
// Honours REG_BYPASS_EN in the same way as the design.
module tb_reg_bank;

   typedef logic [7:0][7:0]  bytes_t;
   typedef logic [3:0][15:0] words_t;

   logic        CLK;
   logic        RST;
   logic [11:0] WE;
   logic [15:0] DIN;
   logic        RD_EN;
   logic        RW_A;
   logic        RW_B;
   logic [3:0]  RSEL_A;
   logic [3:0]  RSEL_B;
   logic [15:0] DOUT_A;
   logic [15:0] DOUT_B;
   logic        RD_VALID;

   int n_chk  = 0;
   int n_fail = 0;

   reg_bank dut (
      .CLK      (CLK),
      .RST      (RST),
      .WE       (WE),
      .DIN      (DIN),
      .RD_EN    (RD_EN),
      .RW_A     (RW_A),
      .RW_B     (RW_B),
      .RSEL_A   (RSEL_A),
      .RSEL_B   (RSEL_B),
      .DOUT_A   (DOUT_A),
      .DOUT_B   (DOUT_B),
      .RD_VALID (RD_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: byte k = AL,CL,DL,BL,AH,CH,DH,BH (enable WE[11-k]); word j = SP..DI (WE[3-j])
   bytes_t mb;
   words_t mw;
   bytes_t nb;
   words_t nw;
   bytes_t rb;
   words_t rw;
   logic [15:0] m_a;
   logic [15:0] m_b;
   logic        m_v;

   function automatic bytes_t f_wb(bytes_t b, logic [11:0] we, logic [15:0] d);
      bytes_t r = b;
      for (int i = 0; i < 4; i++) begin
         if (we[11-i])
            r[i] = d[7:0];
         if (we[7-i])
            r[i+4] = we[11-i] ? d[15:8] : d[7:0];
      end
      return r;
   endfunction

   function automatic words_t f_ww(words_t w, logic [11:0] we, logic [15:0] d);
      words_t r = w;
      for (int j = 0; j < 4; j++)
         if (we[3-j])
            r[j] = d;
      return r;
   endfunction

   function automatic logic [15:0] f_rd(logic w, logic [3:0] sel, bytes_t b, words_t wd);
      int k;
      k = int'(sel[2:0]);
      if (!w)
         return {8'h00, b[k]};
      if (k >= 4)
         return wd[k-4];
      return {b[k+4], b[k]};
   endfunction

   assign nb = f_wb(mb, WE, DIN);
   assign nw = f_ww(mw, WE, DIN);
`ifdef REG_BYPASS_EN
   assign rb = nb;
   assign rw = nw;
`else
   assign rb = mb;
   assign rw = mw;
`endif

   always @(posedge CLK) begin
      if (RST) begin
         mb  <= '0;
         mw  <= '0;
         m_a <= '0;
         m_b <= '0;
         m_v <= 1'b0;
      end else begin
         mb  <= nb;
         mw  <= nw;
         m_v <= RD_EN;
         if (RD_EN) begin
            m_a <= f_rd(RW_A, RSEL_A, rb, rw);
            m_b <= f_rd(RW_B, RSEL_B, rb, rw);
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      chk("model_dout_a", DOUT_A, m_a);
      chk("model_dout_b", DOUT_B, m_b);
      chk("model_valid", {15'd0, RD_VALID}, {15'd0, m_v});
   end

   task automatic drive(input logic rst, input logic [11:0] we, input logic [15:0] din,
                        input logic en, input logic wa, input logic [3:0] sa,
                        input logic wb, input logic [3:0] sb);
      RST    = rst;
      WE     = we;
      DIN    = din;
      RD_EN  = en;
      RW_A   = wa;
      RSEL_A = sa;
      RW_B   = wb;
      RSEL_B = sb;
      @(negedge CLK);
   endtask

   task automatic idle();
      drive(1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   initial begin
      RST = 1'b1; WE = '0; DIN = '0; RD_EN = 1'b0;
      RW_A = 1'b0; RW_B = 1'b0; RSEL_A = '0; RSEL_B = '0;
      @(negedge CLK);
      drive(1'b1, 12'h000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("rst_dout_a", DOUT_A, 16'h0000);
      chk("rst_dout_b", DOUT_B, 16'h0000);
      chk("rst_valid", {15'd0, RD_VALID}, 16'h0000);

      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 4'(i), 1'b1, 4'(7 - i));
         chk("init_word_a", DOUT_A, 16'h0000);
         chk("init_word_b", DOUT_B, 16'h0000);
         chk("init_valid", {15'd0, RD_VALID}, 16'h0001);
      end
      idle();
      chk("valid_drop", {15'd0, RD_VALID}, 16'h0000);

      drive(1'b0, 12'h880, 16'h1234, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0);
      chk("ax_word", DOUT_A, 16'h1234);
      chk("al_byte", DOUT_B, 16'h0034);
      drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 4'd4, 1'b0, 4'd8);
      chk("ah_byte", DOUT_A, 16'h0012);
      chk("al_sel3", DOUT_B, 16'h0034);

      drive(1'b0, 12'h080, 16'h00AB, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1, 4'd8);
      chk("ah_only", DOUT_A, 16'hAB34);
      chk("ah_only_sel3", DOUT_B, 16'hAB34);
      drive(1'b0, 12'h008, 16'hFFFE, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 4'd4, 1'b1, 4'd0);
      chk("sp_word", DOUT_A, 16'hFFFE);
      chk("ax_kept", DOUT_B, 16'hAB34);

      drive(1'b0, 12'h220, 16'h5A5A, 1'b1, 1'b1, 4'd2, 1'b0, 4'd6);
`ifdef REG_BYPASS_EN
      chk("dx_same", DOUT_A, 16'h5A5A);
      chk("dh_same", DOUT_B, 16'h005A);
`else
      chk("dx_same", DOUT_A, 16'h0000);
      chk("dh_same", DOUT_B, 16'h0000);
`endif
      drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 4'd2, 1'b0, 4'd2);
      chk("dx_next", DOUT_A, 16'h5A5A);
      chk("dl_next", DOUT_B, 16'h005A);

      drive(1'b0, 12'h110, 16'hC3F0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3);
      chk("bx_word", DOUT_A, 16'hC3F0);
      chk("bl_byte", DOUT_B, 16'h00F0);

      drive(1'b1, 12'hFFF, 16'hFFFF, 1'b1, 1'b1, 4'd0, 1'b1, 4'd4);
      chk("rstwr_valid", {15'd0, RD_VALID}, 16'h0000);
      chk("rstwr_dout_a", DOUT_A, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 4'(i), 1'b0, 4'(i));
         chk("post_rst_word", DOUT_A, 16'h0000);
         chk("post_rst_byte", DOUT_B, 16'h0000);
      end

      for (int n = 0; n < 3000; n++) begin
         logic [11:0] we;
         we = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
         drive(($urandom_range(0, 63) == 0), we, 16'($urandom),
               ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
               1'($urandom), 4'($urandom));
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
